pc_sequencer: RTL

//  Controller for the program-counter register in the single-cycle core.
//  - Computes next_pc by priority: trap > jump > branch > pc+4.
//  - Drives the PC register's hold (finish_flag) input for boot, stall, halt and fault.
//  - Runs the boot / run / drain / halt lifecycle, so the PC register stays a plain flop.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_next_mux.sv | 39 +++
 rtl/pc_sequencer.sv | 117 +++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, redirect sources,
// the sentinel PC and the alignment mask.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } pc_seq_state_e;

    typedef enum logic [1:0] {
        SRC_SEQ  = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_TRAP = 2'd3
    } redirect_src_e;

    localparam logic [31:0] PC_SENTINEL     = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ADDR_ALIGN_MASK) != 32'h0;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the core datapath (master) and the PC sequencer (slave).
// With PC_SEQ_PERF_EN defined, the bundle also carries the performance counters.
interface pc_sequencer_if;
    logic [31:0] pc_cur;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic        halt_req;
    logic [31:0] next_pc;
    logic        pc_hold;
    logic        halted;
    logic        fault;
    logic [2:0]  state_o;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
`endif

    modport master (
        output pc_cur, stall, br_taken, br_target, jump, jump_target,
               trap, trap_vector, halt_req,
`ifdef PC_SEQ_PERF_EN
        input  cycle_count, retired_count,
`endif
        input  next_pc, pc_hold, halted, fault, state_o
    );

    modport slave (
        input  pc_cur, stall, br_taken, br_target, jump, jump_target,
               trap, trap_vector, halt_req,
`ifdef PC_SEQ_PERF_EN
        output cycle_count, retired_count,
`endif
        output next_pc, pc_hold, halted, fault, state_o
    );
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC priority select (trap > jump > branch > pc+4) with misaligned-redirect detection.
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic [31:0]   i_pc_cur,
    input  logic          i_br_taken,
    input  logic [31:0]   i_br_target,
    input  logic          i_jump,
    input  logic [31:0]   i_jump_target,
    input  logic          i_trap,
    input  logic [31:0]   i_trap_vector,
    output logic [31:0]   o_next_pc,
    output redirect_src_e o_src,
    output logic          o_misalign
);

    // The sentinel PC restarts the program and overrides every redirect.
    always_comb begin
        o_src     = SRC_SEQ;
        o_next_pc = i_pc_cur + 32'd4;
        if (i_pc_cur == PC_SENTINEL) begin
            o_next_pc = RESET_VECTOR;
        end else if (i_trap) begin
            o_src     = SRC_TRAP;
            o_next_pc = i_trap_vector;
        end else if (i_jump) begin
            o_src     = SRC_JMP;
            o_next_pc = i_jump_target;
        end else if (i_br_taken) begin
            o_src     = SRC_BR;
            o_next_pc = i_br_target;
        end
    end

    assign o_misalign = (o_src != SRC_SEQ) && is_misaligned(o_next_pc);

endmodule

// File: rtl/pc_sequencer.sv
// PC-register controller: next-PC select plus boot/run/drain/halt/fault lifecycle.
// Optional PC_SEQ_PERF_EN adds saturating cycle and retired-instruction counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_WORDS   = 256,
    parameter int          BOOT_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    localparam logic [31:0] LAST_ADDR = 32'(4 * IMEM_WORDS - 4);
    localparam int          CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    pc_seq_state_e    r_state;
    logic [CNT_W-1:0] r_boot_cnt;
    logic             r_halted;
    logic             r_fault;
    logic [31:0]      r_next_pc;

    logic [31:0]      w_mux_next;
    redirect_src_e    w_src;
    logic             w_misalign;
    logic             w_run;
    logic             w_halt_cond;
    logic             w_hold;

    pc_next_mux #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_mux (
        .i_pc_cur      (bus.pc_cur),
        .i_br_taken    (bus.br_taken),
        .i_br_target   (bus.br_target),
        .i_jump        (bus.jump),
        .i_jump_target (bus.jump_target),
        .i_trap        (bus.trap),
        .i_trap_vector (bus.trap_vector),
        .o_next_pc     (w_mux_next),
        .o_src         (w_src),
        .o_misalign    (w_misalign)
    );

    assign w_run       = (r_state == S_RUN);
    assign w_halt_cond = bus.halt_req | ((bus.pc_cur == LAST_ADDR) && (w_src == SRC_SEQ));
    assign w_hold      = !w_run | bus.stall | w_misalign | w_halt_cond;

    // Outside RUN the PC is held, so the last RUN-computed target is simply replayed.
    assign bus.next_pc = w_run ? w_mux_next : r_next_pc;
    assign bus.pc_hold = w_hold;
    assign bus.halted  = r_halted;
    assign bus.fault   = r_fault;
    assign bus.state_o = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= '0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
            r_next_pc  <= RESET_VECTOR;
        end else begin
            case (r_state)
                S_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_state <= S_RUN;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_next_pc <= w_mux_next;
                    // A bad redirect wins over halting and is never masked by stall.
                    if (w_misalign) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (w_halt_cond) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state  <= S_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_retired_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else if (w_run) begin
            if (r_cycle_count != 32'hFFFF_FFFF) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (!w_hold && (bus.pc_cur != PC_SENTINEL) && (r_retired_count != 32'hFFFF_FFFF)) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
        end
    end

    assign bus.cycle_count   = r_cycle_count;
    assign bus.retired_count = r_retired_count;
`endif

endmodule
